// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the FSM state type, the port identifiers and the default watchdog limit.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_PTW = 1'b0;
  localparam logic ARB_PORT_CPU = 1'b1;

  localparam int ARB_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Watchdog for a stalled downstream access.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   count_en   : request outstanding and not completed this cycle
//   clear      : restart the count (nothing waiting this cycle)
//   timeout    : one-cycle pulse in the cycle the limit is reached
// TIMEOUT_CYCLES = 0 disables the watchdog: the counter stays at zero and
// timeout never fires.
module arb_watchdog
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  parameter int TO_WIDTH       = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);

  localparam bit                  ENABLE  = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(ENABLE ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TO_WIDTH-1:0] TO_MAX  = '1;

  logic [TO_WIDTH-1:0] to_cnt;

  // Fires in the cycle whose count already equals the limit minus one, so the
  // error completion lands on the TIMEOUT_CYCLES-th stalled cycle.
  assign timeout = ENABLE && count_en && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || timeout || !ENABLE) begin
      to_cnt <= '0;
    end else if (count_en && (to_cnt != TO_MAX)) begin
      // Saturate rather than wrap.
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single memory port.
// Port 0 is the page-table walker, port 1 the CPU control path.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   m0_* / m1_*                    : requester sides (valid/addr/wdata/wstrb in,
//                                    ready/rdata/err out); m1_lock keeps the CPU
//                                    grant across successive transactions
//   s_*                            : downstream request and completion
//   grant_id, busy                 : current owner and "not idle" (FSM view)
// Handshake: a requester raises mX_valid with stable addr/wdata/wstrb and holds
// it until the cycle mX_ready=1; that cycle is the completion (mX_err=1 marks a
// watchdog abort, with rdata forced to 0). Downstream, s_valid is held until a
// one-cycle s_ready pulse, which completes the access in the same cycle.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  parameter int TO_WIDTH       = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  input  logic        m1_lock,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant_id,
  output logic        busy
);

  arb_state_t state;
  logic       last_grant;
  logic       g0, g1, req, done, timeout;

  assign g0   = (state == ARB_GRANT0);
  assign g1   = (state == ARB_GRANT1);
  assign req  = (g0 && m0_valid) || (g1 && m1_valid);
  assign done = req && s_ready;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .count_en(req && !s_ready),
    .clear   (!(req && !s_ready)),
    .timeout (timeout)
  );

  always_comb begin
    s_valid = req;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (req) begin
      s_addr  = g1 ? m1_addr  : m0_addr;
      s_wdata = g1 ? m1_wdata : m0_wdata;
      s_wstrb = g1 ? m1_wstrb : m0_wstrb;
    end
  end

  assign m0_ready = g0 && (done || timeout);
  assign m0_err   = g0 && timeout;
  assign m0_rdata = (g0 && done) ? s_rdata : '0;
  assign m1_ready = g1 && (done || timeout);
  assign m1_err   = g1 && timeout;
  assign m1_rdata = (g1 && done) ? s_rdata : '0;

  assign busy     = (state != ARB_IDLE);
  assign grant_id = g1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_PORT_CPU;
    end else begin
      case (state)
        ARB_IDLE: begin
          // s_ready is ignored here; a tie goes to the port that did not win last.
          if (m0_valid && m1_valid) begin
            state <= (last_grant == ARB_PORT_PTW) ? ARB_GRANT1 : ARB_GRANT0;
          end else if (m0_valid) begin
            state <= ARB_GRANT0;
          end else if (m1_valid) begin
            state <= ARB_GRANT1;
          end
        end
        ARB_GRANT0: begin
          if (done || timeout) begin
            last_grant <= ARB_PORT_PTW;
            state      <= ARB_IDLE;
          end else if (!m0_valid) begin
            state <= ARB_IDLE;
          end
        end
        ARB_GRANT1: begin
          if (done) begin
            last_grant <= ARB_PORT_CPU;
            state      <= m1_lock ? ARB_GRANT1 : ARB_IDLE;
          end else if (timeout) begin
            // An aborted access drops the lock so the PTW is not starved.
            last_grant <= ARB_PORT_CPU;
            state      <= ARB_IDLE;
          end else if (!m1_valid) begin
            state <= m1_lock ? ARB_GRANT1 : ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid, m1_lock, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m0_err, m1_ready, m1_err, s_valid, grant_id, busy;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err), .m1_lock(m1_lock),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner of the port (-1 none), who won last, and how many
  // stalled cycles the current access has accumulated.
  int  own    = -1;
  int  lastp  = 1;
  int  waited = 0;
  bit  model_ok = 0;

  always @(negedge clk) begin : compare
    bit          rq, dn, tmo;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    rq  = (own == 0) ? m0_valid : (own == 1) ? m1_valid : 1'b0;
    dn  = rq && s_ready;
    tmo = (TO > 0) && rq && !s_ready && (waited == TO - 1);
    ea  = !rq ? 32'h0 : (own == 1) ? m1_addr  : m0_addr;
    ew  = !rq ? 32'h0 : (own == 1) ? m1_wdata : m0_wdata;
    es  = !rq ? 4'h0  : (own == 1) ? m1_wstrb : m0_wstrb;
    if (model_ok) begin
      chk("s_valid",  {31'b0, s_valid},  {31'b0, rq});
      chk("s_addr",   s_addr,  ea);
      chk("s_wdata",  s_wdata, ew);
      chk("s_wstrb",  {28'b0, s_wstrb}, {28'b0, es});
      chk("m0_ready", {31'b0, m0_ready}, {31'b0, (own == 0) && (dn || tmo)});
      chk("m0_err",   {31'b0, m0_err},   {31'b0, (own == 0) && tmo});
      chk("m0_rdata", m0_rdata, ((own == 0) && dn) ? s_rdata : 32'h0);
      chk("m1_ready", {31'b0, m1_ready}, {31'b0, (own == 1) && (dn || tmo)});
      chk("m1_err",   {31'b0, m1_err},   {31'b0, (own == 1) && tmo});
      chk("m1_rdata", m1_rdata, ((own == 1) && dn) ? s_rdata : 32'h0);
      chk("busy",     {31'b0, busy},     {31'b0, own != -1});
      chk("grant_id", {31'b0, grant_id}, {31'b0, own == 1});
    end
    if (reset) begin
      own = -1; lastp = 1; waited = 0; model_ok = 1;
    end else if (own == -1) begin
      if (m0_valid && m1_valid) own = 1 - lastp;
      else if (m0_valid)        own = 0;
      else if (m1_valid)        own = 1;
      waited = 0;
    end else if (dn || tmo) begin
      lastp  = own;
      own    = (own == 1 && m1_lock && dn) ? 1 : -1;
      waited = 0;
    end else if (!rq) begin
      own    = (own == 1 && m1_lock) ? 1 : -1;
      waited = 0;
    end else begin
      waited++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  initial begin : bound
    #200000;
    $display("FAIL time_bound: simulation exceeded limit");
    $fatal(1, "time bound");
  end

  initial begin : stim
    reset = 1; m0_valid = 0; m1_valid = 0; m1_lock = 0; s_ready = 0;
    m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; s_rdata = 0;
    repeat (3) tick();
    reset = 0;
    probe();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_s_valid", {31'b0, s_valid}, 32'h0);
    chk("rst_grant", {31'b0, grant_id}, 32'h0);

    // Tie after reset: port 0 wins, then port 1 after the bubble.
    tick();
    m0_valid = 1; m0_addr = 32'h1000_0000; m0_wdata = 32'h0000_0011; m0_wstrb = 4'h0;
    m1_valid = 1; m1_addr = 32'h8000_0010; m1_wstrb = 4'h0;
    probe(); chk("tie_idle_s_valid", {31'b0, s_valid}, 32'h0);
    tick();
    probe();
    chk("tie_grant", {31'b0, grant_id}, 32'h0);
    chk("tie_s_valid", {31'b0, s_valid}, 32'h1);
    chk("tie_s_addr", s_addr, 32'h1000_0000);
    tick(); tick();
    s_ready = 1; s_rdata = 32'h0BAD_F00D;
    probe();
    chk("p0_ready", {31'b0, m0_ready}, 32'h1);
    chk("p0_rdata", m0_rdata, 32'h0BAD_F00D);
    chk("p0_other_ready", {31'b0, m1_ready}, 32'h0);
    tick(); s_ready = 0; m0_valid = 0;
    probe(); chk("bubble_busy", {31'b0, busy}, 32'h0);
    tick();
    probe();
    chk("p1_grant", {31'b0, grant_id}, 32'h1);
    chk("p1_s_addr", s_addr, 32'h8000_0010);
    tick(); tick();
    s_ready = 1; s_rdata = 32'hDEAD_BEEF;
    probe();
    chk("p1_ready", {31'b0, m1_ready}, 32'h1);
    chk("p1_rdata", m1_rdata, 32'hDEAD_BEEF);
    tick(); s_ready = 0; m1_valid = 0;
    probe(); chk("p1_busy_after", {31'b0, busy}, 32'h0);

    // Locked LR/SC pair with the PTW requesting throughout.
    m1_valid = 1; m1_lock = 1; m1_addr = 32'h8000_0020; m1_wstrb = 4'h0;
    tick();
    m0_valid = 1; m0_addr = 32'h1000_0040; m0_wstrb = 4'h0;
    probe(); chk("lr_grant", {31'b0, grant_id}, 32'h1);
    tick(); s_ready = 1; s_rdata = 32'h1234_5678;
    probe(); chk("lr_ready", {31'b0, m1_ready}, 32'h1);
    tick(); s_ready = 0; m1_valid = 0;
    probe();
    chk("hold_busy", {31'b0, busy}, 32'h1);
    chk("hold_grant", {31'b0, grant_id}, 32'h1);
    chk("hold_s_valid", {31'b0, s_valid}, 32'h0);
    tick(); m1_valid = 1; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    probe();
    chk("sc_grant", {31'b0, grant_id}, 32'h1);
    chk("sc_wstrb", {28'b0, s_wstrb}, 32'hF);
    tick(); s_ready = 1; s_rdata = 32'h0; m1_lock = 0;
    probe(); chk("sc_ready", {31'b0, m1_ready}, 32'h1);
    tick(); s_ready = 0; m1_valid = 0;
    probe(); chk("unlock_busy", {31'b0, busy}, 32'h0);
    tick();
    probe();
    chk("ptw_grant", {31'b0, grant_id}, 32'h0);
    chk("ptw_s_addr", s_addr, 32'h1000_0040);
    tick(); s_ready = 1;
    probe(); chk("ptw_ready", {31'b0, m0_ready}, 32'h1);
    tick(); s_ready = 0; m0_valid = 0;

    // Watchdog: no s_ready, error on the 8th cycle of s_valid.
    m0_valid = 1; m0_addr = 32'h1000_0080; s_rdata = 32'hA5A5_A5A5;
    tick();
    repeat (6) tick();
    probe(); chk("to_early_ready", {31'b0, m0_ready}, 32'h0);
    tick();
    probe();
    chk("to_ready", {31'b0, m0_ready}, 32'h1);
    chk("to_err", {31'b0, m0_err}, 32'h1);
    chk("to_rdata", m0_rdata, 32'h0);
    tick(); m0_valid = 0; s_ready = 1;
    probe();
    chk("late_ready", {31'b0, m0_ready}, 32'h0);
    chk("late_busy", {31'b0, busy}, 32'h0);
    tick(); s_ready = 0;

    // s_ready in the timeout cycle: normal completion.
    m0_valid = 1;
    tick();
    repeat (6) tick();
    tick(); s_ready = 1;
    probe();
    chk("race_ready", {31'b0, m0_ready}, 32'h1);
    chk("race_err", {31'b0, m0_err}, 32'h0);
    chk("race_rdata", m0_rdata, 32'hA5A5_A5A5);
    tick(); s_ready = 0; m0_valid = 0;

    // Reset in the middle of a CPU access.
    m1_valid = 1; m1_addr = 32'h8000_0030; m1_wstrb = 4'h0;
    tick();
    probe(); chk("pre_rst_s_valid", {31'b0, s_valid}, 32'h1);
    tick(); reset = 1;
    tick(); reset = 0; m0_valid = 1;
    probe();
    chk("post_rst_s_valid", {31'b0, s_valid}, 32'h0);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_m1_ready", {31'b0, m1_ready}, 32'h0);
    tick();
    probe(); chk("post_rst_grant", {31'b0, grant_id}, 32'h0);
    tick(); s_ready = 1;
    tick(); s_ready = 0; m0_valid = 0;
    tick(); tick(); s_ready = 1;
    tick(); s_ready = 0; m1_valid = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
